// File: rtl/contador_bcd_2dig.sv
// Two-digit BCD up/down counter with a prescaler, BCD preset with validity check,
// terminal count, and a display enable that comes up one cycle after reset release.
module contador_bcd_2dig #(
  parameter int unsigned DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       up_down,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] unid,
  output logic [3:0] dez,
  output logic       tick,
  output logic       tc,
  output logic       load_err,
  output logic       display_en
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  typedef enum logic {
    PARADO   = 1'b0,
    CONTANDO = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc_next;
  logic [3:0]      r_unid;
  logic [3:0]      r_dez;
  logic [3:0]      w_unid_next;
  logic [3:0]      w_dez_next;
  logic            r_tick;
  logic            r_load_err;
  logic [1:0]      r_disp;
  logic            w_load_ok;
  logic            w_load_bad;
  logic            w_step;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) r_state <= PARADO;
    else       r_state <= w_next;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      PARADO:   if (enable)  w_next = CONTANDO;
      CONTANDO: if (!enable) w_next = PARADO;
      default:  w_next = PARADO;
    endcase
  end

  always_comb begin
    w_load_ok  = load && (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
    w_load_bad = load && !w_load_ok;
    // Any load request, even a rejected one, suppresses the step on that edge.
    w_step     = (r_state == CONTANDO) && enable && (r_presc == PS_LAST) && !load;

    w_presc_next = r_presc;
    if (w_load_ok || (w_next == PARADO))
      w_presc_next = '0;
    else if (r_state == CONTANDO)
      w_presc_next = (r_presc == PS_LAST) ? '0 : r_presc + PW'(1);

    w_unid_next = r_unid;
    w_dez_next  = r_dez;
    if (w_load_ok) begin
      w_unid_next = load_val[3:0];
      w_dez_next  = load_val[7:4];
    end else if (w_step) begin
      // Wrap tests use >=/== against the digit limits so the digits stay 0..9.
      if (up_down) begin
        if (r_unid >= 4'd9) begin
          w_unid_next = 4'd0;
          w_dez_next  = (r_dez >= 4'd9) ? 4'd0 : r_dez + 4'd1;
        end else begin
          w_unid_next = r_unid + 4'd1;
        end
      end else begin
        if (r_unid == 4'd0 || r_unid > 4'd9) begin
          w_unid_next = 4'd9;
          w_dez_next  = (r_dez == 4'd0 || r_dez > 4'd9) ? 4'd9 : r_dez - 4'd1;
        end else begin
          w_unid_next = r_unid - 4'd1;
        end
      end
    end
  end

  // NOTE: reset is synchronous; every control and data register is cleared so
  // no progress survives, including a step pending on the reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc    <= '0;
      r_unid     <= 4'd0;
      r_dez      <= 4'd0;
      r_tick     <= 1'b0;
      r_load_err <= 1'b0;
      r_disp     <= 2'b00;
    end else begin
      r_presc    <= w_presc_next;
      r_unid     <= w_unid_next;
      r_dez      <= w_dez_next;
      r_tick     <= w_step;
      r_load_err <= w_load_bad;
      r_disp     <= {r_disp[0], 1'b1};
    end
  end

  assign unid       = r_unid;
  assign dez        = r_dez;
  assign tick       = r_tick;
  assign load_err   = r_load_err;
  assign display_en = r_disp[1];
  assign tc = ( up_down && (r_dez == 4'd9) && (r_unid == 4'd9)) ||
              (!up_down && (r_dez == 4'd0) && (r_unid == 4'd0));

endmodule

// File: tb/tb_contador_bcd_2dig.sv
// Self-checking bench for contador_bcd_2dig: a decimal-arithmetic model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_contador_bcd_2dig;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset, enable, up_down, load;
  logic [7:0] load_val;
  logic [3:0] unid, dez;
  logic       tick, tc, load_err, display_en;

  int checks = 0;
  int errors = 0;

  contador_bcd_2dig #(.DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_val   (load_val),
    .unid       (unid),
    .dez        (dez),
    .tick       (tick),
    .tc         (tc),
    .load_err   (load_err),
    .display_en (display_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the count is a plain integer 0..99.
  bit m_known = 0;
  bit m_run;
  int m_ps, m_cnt, m_since;
  bit m_tick, m_err, m_ok, m_stp;

  always @(posedge clk) begin
    if (reset) begin
      m_known = 1; m_run = 0; m_ps = 0; m_cnt = 0;
      m_tick = 0; m_err = 0; m_since = 0;
    end else if (m_known) begin
      m_ok   = load && (load_val[7:4] <= 9) && (load_val[3:0] <= 9);
      m_stp  = m_run && enable && (m_ps == DIV - 1) && !load;
      m_tick = m_stp;
      m_err  = load && !m_ok;
      if (m_ok)       m_cnt = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
      else if (m_stp) m_cnt = up_down ? (m_cnt + 1) % 100 : (m_cnt + 99) % 100;
      if (m_ok || !enable) m_ps = 0;
      else if (m_run)      m_ps = (m_ps + 1) % DIV;
      m_run = enable;
      if (m_since < 2) m_since++;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("m_unid", unid, m_cnt % 10);
      check("m_dez", dez, m_cnt / 10);
      check("m_tick", tick, m_tick);
      check("m_load_err", load_err, m_err);
      check("m_display_en", display_en, (m_since >= 2) ? 1 : 0);
      check("m_tc", tc, ((up_down && m_cnt == 99) || (!up_down && m_cnt == 0)) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(output int waited);
    waited = 0;
    for (int k = 0; k < 50; k++) begin
      cyc(1);
      waited++;
      if (tick) break;
    end
    check("tick_seen", tick, 1);
  endtask

  function automatic int cnt_now();
    return int'(dez) * 10 + int'(unid);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, last, nt, exp_cnt;
    reset = 1; enable = 0; up_down = 1; load = 0; load_val = 8'h00;
    cyc(2);
    check("rst_unid", unid, 0);
    check("rst_dez", dez, 0);
    check("rst_tick", tick, 0);
    check("rst_load_err", load_err, 0);
    check("rst_display_en", display_en, 0);
    check("rst_tc_up", tc, 0);
    up_down = 0; #1;
    check("rst_tc_down", tc, 1);
    up_down = 1;

    reset = 0;
    cyc(1); check("disp_rel1", display_en, 0);
    cyc(1); check("disp_rel2", display_en, 1);

    // Sweep: 100 steps from 00 wrap back to 00, one every DIV cycles.
    enable = 1; exp_cnt = 0; last = -1; nt = 0;
    for (int i = 0; i < 402; i++) begin
      cyc(1);
      if (tick) begin
        exp_cnt = (exp_cnt + 1) % 100;
        nt++;
        if (last >= 0) check("sweep_gap", i - last, 4);
        last = i;
        check("sweep_cnt", cnt_now(), exp_cnt);
      end
    end
    check("sweep_ticks", nt, 100);
    check("sweep_wrap", cnt_now(), 0);

    // Down wrap from 01.
    up_down = 0; load = 1; load_val = 8'h01;
    cyc(1); load = 0;
    check("dw_load", cnt_now(), 1);
    wait_tick(w); check("dw_gap", w, 4); check("dw_00", cnt_now(), 0); check("dw_tc00", tc, 1);
    wait_tick(w); check("dw_99", cnt_now(), 99); check("dw_tc99", tc, 0);
    wait_tick(w); check("dw_98", cnt_now(), 98);

    // Load colliding with a step: load wins, step lost.
    up_down = 1;
    cyc(3); load = 1; load_val = 8'h45;
    cyc(1); load = 0;
    check("col_cnt", cnt_now(), 45);
    check("col_tick", tick, 0);
    wait_tick(w); check("col_gap", w, 4); check("col_46", cnt_now(), 46);

    // Rejected load keeps count and prescaler phase.
    load = 1; load_val = 8'h12;
    cyc(1); load = 0;
    check("bad_pre", cnt_now(), 12);
    cyc(1); load = 1; load_val = 8'h3A;
    cyc(1); load = 0;
    check("bad_err", load_err, 1);
    check("bad_cnt", cnt_now(), 12);
    cyc(1); check("bad_err_off", load_err, 0);
    wait_tick(w); check("bad_gap", w, 1); check("bad_13", cnt_now(), 13);

    // Pause at prescaler=2 for 5 cycles.
    cyc(2); enable = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("pause_tick", tick, 0);
    end
    enable = 1;
    wait_tick(w); check("pause_gap", w, 5); check("pause_14", cnt_now(), 14);

    // Reset in the tick cycle with count 57.
    load = 1; load_val = 8'h56;
    cyc(1); load = 0;
    wait_tick(w); check("rm_57", cnt_now(), 57);
    reset = 1;
    cyc(1);
    check("rm_unid", unid, 0);
    check("rm_dez", dez, 0);
    check("rm_tick", tick, 0);
    check("rm_disp", display_en, 0);
    reset = 0;
    cyc(1); check("rm_disp1", display_en, 0);
    cyc(1); check("rm_disp2", display_en, 1);

    // Load while stopped; the count must then hold.
    enable = 0; load = 1; load_val = 8'h99;
    cyc(1); load = 0;
    check("idle_load", cnt_now(), 99);
    check("idle_tc", tc, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check("idle_tick", tick, 0);
    end
    check("idle_hold", cnt_now(), 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
